// File: rtl/guess_input_capture_if.sv
// guess_input_capture_if: raw key/switch inputs and debounced press outputs.
interface guess_input_capture_if #(
  parameter int CODE_W = 5
);
  logic              key_n;
  logic [CODE_W-1:0] sw_code;
  logic              strobe;
  logic [CODE_W-1:0] code;
  logic              zero_press;
  logic              pressed;
  modport master (output key_n, sw_code, input strobe, code, zero_press, pressed);
  modport slave (input key_n, sw_code, output strobe, code, zero_press, pressed);
endinterface

// File: rtl/guess_input_capture.sv
// guess_input_capture: synchronise and debounce the letter key, emit one strobe per clean press.
module guess_input_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CODE_W          = 5
) (
  input logic                  clk,
  input logic                  rst,
  guess_input_capture_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic key_s1_q, key_s_q;
  logic [CODE_W-1:0] sw_s1_q, sw_s_q;
  logic [CODE_W-1:0] code_q, code_d;
  logic strobe_q, strobe_d, zero_q, zero_d, pressed_q, pressed_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1_q  <= 1'b1;
      key_s_q   <= 1'b1;
      sw_s1_q   <= '0;
      sw_s_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= '0;
      strobe_q  <= 1'b0;
      zero_q    <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      key_s1_q  <= io.key_n;
      key_s_q   <= key_s1_q;
      sw_s1_q   <= io.sw_code;
      sw_s_q    <= sw_s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      strobe_q  <= strobe_d;
      zero_q    <= zero_d;
      pressed_q <= pressed_d;
    end
  end
  // Any key level that breaks the current run sends the FSM back before the count can finish.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (!key_s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      PRESS_WAIT:
        if (key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      PRESSED:
        if (key_s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      RELEASE_WAIT:
        if (!key_s_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
    endcase
  end
  always_comb begin
    strobe_d  = (state_q == PRESS_WAIT) && (state_d == PRESSED) && (|sw_s_q);
    zero_d    = (state_q == PRESS_WAIT) && (state_d == PRESSED) && !(|sw_s_q);
    code_d    = (state_q == PRESS_WAIT) && (state_d == PRESSED) ? sw_s_q : code_q;
    pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end
  assign io.strobe     = strobe_q;
  assign io.zero_press = zero_q;
  assign io.code       = code_q;
  assign io.pressed    = pressed_q;
endmodule

// File: tb/tb_guess_input_capture.sv
// tb_guess_input_capture: directed press scenarios with a scoreboard of expected strobe/zero_press pulses.
module tb_guess_input_capture;
  localparam int D = 4;
  typedef struct {
    logic       zero;
    logic [4:0] code;
    int         at;
  } pulse_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  pulse_t exp_q[$];
  guess_input_capture_if #(.CODE_W(5)) bus();
  guess_input_capture #(.DEBOUNCE_CYCLES(D), .CODE_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [4:0] c, input bit expect_pulse);
    bus.sw_code = c;
    bus.key_n   = 1'b0;
    if (expect_pulse) exp_q.push_back('{c == 5'd0, c, cyc + D + 2});
  endtask
  always @(negedge clk) begin
    if (bus.strobe || bus.zero_press) begin
      check("pulse_exclusive", {31'd0, bus.strobe & bus.zero_press}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_pulse", {27'd0, bus.code}, 32'hFFFF_FFFF);
      else begin
        pulse_t e;
        e = exp_q.pop_front();
        check("pulse_kind_zero", {31'd0, bus.zero_press}, {31'd0, e.zero});
        check("pulse_code", {27'd0, bus.code}, {27'd0, e.code});
        check("pulse_time", cyc, e.at);
      end
    end
  end
  initial begin
    bus.key_n   = 1'b1;
    bus.sw_code = 5'd0;
    step(3);
    check("rst_strobe", {31'd0, bus.strobe}, 32'd0);
    check("rst_zero", {31'd0, bus.zero_press}, 32'd0);
    check("rst_code", {27'd0, bus.code}, 32'd0);
    check("rst_pressed", {31'd0, bus.pressed}, 32'd0);
    rst = 1'b1;
    step(4);
    // clean press and release
    press(5'b00110, 1'b1);
    step(20);
    check("clean_pressed", {31'd0, bus.pressed}, 32'd1);
    check("clean_code", {27'd0, bus.code}, 32'b00110);
    bus.key_n = 1'b1;
    step(5);
    check("clean_release_hold", {31'd0, bus.pressed}, 32'd1);
    step(1);
    check("clean_release_low", {31'd0, bus.pressed}, 32'd0);
    step(6);
    // bounce on press
    bus.sw_code = 5'b01001;
    for (int i = 0; i < 3; i++) begin
      bus.key_n = 1'b0;
      step(2);
      bus.key_n = 1'b1;
      step(2);
    end
    check("bounce_no_press", {31'd0, bus.pressed}, 32'd0);
    press(5'b01001, 1'b1);
    step(10);
    bus.key_n = 1'b1;
    step(10);
    // zero code
    press(5'b00000, 1'b1);
    step(10);
    check("zero_code", {27'd0, bus.code}, 32'd0);
    check("zero_pressed", {31'd0, bus.pressed}, 32'd1);
    bus.key_n = 1'b1;
    step(10);
    // switches change while held
    press(5'b10010, 1'b1);
    step(8);
    bus.sw_code = 5'b01100;
    step(8);
    check("held_code", {27'd0, bus.code}, 32'b10010);
    bus.key_n = 1'b1;
    step(10);
    check("held_code_after", {27'd0, bus.code}, 32'b10010);
    press(5'b01100, 1'b1);
    step(10);
    bus.key_n = 1'b1;
    step(10);
    // release bounce
    press(5'b00011, 1'b1);
    step(10);
    bus.key_n = 1'b1;
    step(2);
    bus.key_n = 1'b0;
    step(2);
    bus.key_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("relbounce_hold", {31'd0, bus.pressed}, 32'd1);
    end
    step(1);
    check("relbounce_low", {31'd0, bus.pressed}, 32'd0);
    step(6);
    // async reset mid press count
    press(5'b10101, 1'b0);
    step(3);
    #2 rst = 1'b0;
    #1;
    check("arst_code", {27'd0, bus.code}, 32'd0);
    check("arst_strobe", {31'd0, bus.strobe}, 32'd0);
    check("arst_zero", {31'd0, bus.zero_press}, 32'd0);
    check("arst_pressed", {31'd0, bus.pressed}, 32'd0);
    step(3);
    rst = 1'b1;
    exp_q.push_back('{1'b0, 5'b10101, cyc + D + 2});
    step(12);
    bus.key_n = 1'b1;
    step(10);
    check("all_pulses_seen", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
